// File: rtl/opendap_apb_arbiter_pkg.sv
// Shared sizing helpers for the OpenDAP APB arbiter and its round-robin picker.
package opendap_apb_arbiter_pkg;

    // Index width that stays legal for a single-port build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold 0..limit, never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/opendap_rr_arbiter.sv
// Combinational round-robin picker: lowest-distance requester after last_grant wins.
module opendap_rr_arbiter
    import opendap_apb_arbiter_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int IDX_W   = idx_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [N_PORTS-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               valid
);

    always_comb begin
        int cand;
        cand      = 0;
        grant_idx = '0;
        valid     = 1'b0;
        // Walk from the farthest candidate to the nearest so the nearest hit overwrites.
        for (int k = N_PORTS; k >= 1; k--) begin
            cand = (int'(last_grant) + k) % N_PORTS;
            if (req[cand]) begin
                grant_idx = IDX_W'(cand);
                valid     = 1'b1;
            end
        end
        grant = valid ? (N_PORTS'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/opendap_apb_arbiter.sv
// N-to-1 APB arbiter: one downstream transfer at a time, round-robin between upstream ports.
module opendap_apb_arbiter
    import opendap_apb_arbiter_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 8,
    parameter int W_DATA  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_PORTS-1:0]        src_psel,
    input  logic [N_PORTS-1:0]        src_penable,
    input  logic [N_PORTS-1:0]        src_pwrite,
    input  logic [N_PORTS*W_ADDR-1:0] src_paddr,
    input  logic [N_PORTS*W_DATA-1:0] src_pwdata,
    output logic [N_PORTS*W_DATA-1:0] src_prdata,
    output logic [N_PORTS-1:0]        src_pready,
    output logic [N_PORTS-1:0]        src_pslverr,
    output logic                      dst_psel,
    output logic                      dst_penable,
    output logic                      dst_pwrite,
    output logic [W_ADDR-1:0]         dst_paddr,
    output logic [W_DATA-1:0]         dst_pwdata,
    input  logic [W_DATA-1:0]         dst_prdata,
    input  logic                      dst_pready,
    input  logic                      dst_pslverr
);

    localparam int IDX_W = idx_width(N_PORTS);
    localparam int CNT_W = cnt_width(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_reg, state_next;
    logic [N_PORTS-1:0]  owner_reg, owner_next;
    logic [IDX_W-1:0]    last_grant_reg, last_grant_next;
    logic                dst_psel_reg, dst_psel_next;
    logic                dst_penable_reg, dst_penable_next;
    logic                dst_pwrite_reg, dst_pwrite_next;
    logic [W_ADDR-1:0]   dst_paddr_reg, dst_paddr_next;
    logic [W_DATA-1:0]   dst_pwdata_reg, dst_pwdata_next;
    logic [W_DATA-1:0]   resp_rdata_reg, resp_rdata_next;
    logic                resp_err_reg, resp_err_next;
    logic [N_PORTS-1:0]  src_pready_reg, src_pready_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                lost_reg, lost_next;

    logic [N_PORTS-1:0]  req;
    logic [N_PORTS-1:0]  gnt_oh;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_valid;
    logic                owner_gone;
    logic                timeout_hit;
    logic [W_ADDR-1:0]   paddr_arr  [N_PORTS];
    logic [W_DATA-1:0]   pwdata_arr [N_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign paddr_arr[gi]                     = src_paddr[gi*W_ADDR +: W_ADDR];
            assign pwdata_arr[gi]                    = src_pwdata[gi*W_DATA +: W_DATA];
            assign src_prdata[gi*W_DATA +: W_DATA]   = resp_rdata_reg;
        end
    endgenerate

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Only access phases count as requests, so a port back in setup is never re-served.
    assign req        = src_psel & src_penable;
    assign owner_gone = lost_reg | ~(|(src_psel & owner_reg));

    assign src_pready  = src_pready_reg;
    assign src_pslverr = {N_PORTS{resp_err_reg}};
    assign dst_psel    = dst_psel_reg;
    assign dst_penable = dst_penable_reg;
    assign dst_pwrite  = dst_pwrite_reg;
    assign dst_paddr   = dst_paddr_reg;
    assign dst_pwdata  = dst_pwdata_reg;

    opendap_rr_arbiter #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant_reg),
        .grant      (gnt_oh),
        .grant_idx  (gnt_idx),
        .valid      (gnt_valid)
    );

    always_comb begin
        state_next       = state_reg;
        owner_next       = owner_reg;
        last_grant_next  = last_grant_reg;
        dst_psel_next    = dst_psel_reg;
        dst_penable_next = dst_penable_reg;
        dst_pwrite_next  = dst_pwrite_reg;
        dst_paddr_next   = dst_paddr_reg;
        dst_pwdata_next  = dst_pwdata_reg;
        resp_rdata_next  = resp_rdata_reg;
        resp_err_next    = resp_err_reg;
        src_pready_next  = '0;
        cnt_next         = cnt_reg;
        lost_next        = lost_reg;

        case (state_reg)
            IDLE: begin
                dst_psel_next    = 1'b0;
                dst_penable_next = 1'b0;
                cnt_next         = '0;
                if (gnt_valid) begin
                    owner_next      = gnt_oh;
                    last_grant_next = gnt_idx;
                    dst_paddr_next  = paddr_arr[gnt_idx];
                    dst_pwdata_next = pwdata_arr[gnt_idx];
                    dst_pwrite_next = src_pwrite[gnt_idx];
                    dst_psel_next   = 1'b1;
                    lost_next       = 1'b0;
                    state_next      = SETUP;
                end
            end
            SETUP: begin
                dst_penable_next = 1'b1;
                cnt_next         = '0;
                lost_next        = owner_gone;
                state_next       = ACCESS;
            end
            ACCESS: begin
                if (dst_pready || timeout_hit) begin
                    dst_psel_next    = 1'b0;
                    dst_penable_next = 1'b0;
                    // An abandoned requester gets no response; the slave access still finishes.
                    if (owner_gone) begin
                        state_next = IDLE;
                    end else begin
                        state_next      = RESP;
                        src_pready_next = owner_reg;
                        resp_rdata_next = dst_pready ? dst_prdata : '0;
                        resp_err_next   = dst_pready ? dst_pslverr : 1'b1;
                    end
                end else begin
                    lost_next = owner_gone;
                    if (TIMEOUT > 0) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            RESP: begin
                dst_psel_next    = 1'b0;
                dst_penable_next = 1'b0;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            owner_reg       <= '0;
            last_grant_reg  <= IDX_W'(N_PORTS - 1);
            dst_psel_reg    <= 1'b0;
            dst_penable_reg <= 1'b0;
            dst_pwrite_reg  <= 1'b0;
            dst_paddr_reg   <= '0;
            dst_pwdata_reg  <= '0;
            resp_rdata_reg  <= '0;
            resp_err_reg    <= 1'b0;
            src_pready_reg  <= '0;
            cnt_reg         <= '0;
            lost_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            last_grant_reg  <= last_grant_next;
            dst_psel_reg    <= dst_psel_next;
            dst_penable_reg <= dst_penable_next;
            dst_pwrite_reg  <= dst_pwrite_next;
            dst_paddr_reg   <= dst_paddr_next;
            dst_pwdata_reg  <= dst_pwdata_next;
            resp_rdata_reg  <= resp_rdata_next;
            resp_err_reg    <= resp_err_next;
            src_pready_reg  <= src_pready_next;
            cnt_reg         <= cnt_next;
            lost_reg        <= lost_next;
        end
    end

endmodule

// File: tb/tb_opendap_apb_arbiter.sv
// Scoreboard bench for opendap_apb_arbiter: two upstream masters and a modelled downstream slave.
module tb_opendap_apb_arbiter;

    localparam int NP = 2;
    localparam int WA = 8;
    localparam int WD = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP-1:0]     src_psel = '0, src_penable = '0, src_pwrite = '0;
    logic [NP*WA-1:0]  src_paddr = '0;
    logic [NP*WD-1:0]  src_pwdata = '0;
    logic [NP*WD-1:0]  src_prdata;
    logic [NP-1:0]     src_pready, src_pslverr;
    logic              dst_psel, dst_penable, dst_pwrite;
    logic [WA-1:0]     dst_paddr;
    logic [WD-1:0]     dst_pwdata;
    logic [WD-1:0]     dst_prdata = '0;
    logic              dst_pready = 1'b0, dst_pslverr = 1'b0;

    opendap_apb_arbiter #(.N_PORTS(NP), .W_ADDR(WA), .W_DATA(WD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_psel(src_psel), .src_penable(src_penable), .src_pwrite(src_pwrite),
        .src_paddr(src_paddr), .src_pwdata(src_pwdata), .src_prdata(src_prdata),
        .src_pready(src_pready), .src_pslverr(src_pslverr),
        .dst_psel(dst_psel), .dst_penable(dst_penable), .dst_pwrite(dst_pwrite),
        .dst_paddr(dst_paddr), .dst_pwdata(dst_pwdata),
        .dst_prdata(dst_prdata), .dst_pready(dst_pready), .dst_pslverr(dst_pslverr)
    );

    always #5 clk = ~clk;

    // s_wait: wait states before the slave answers; negative means it never answers.
    typedef struct {
        int          port;
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] s_rdata;
        logic        s_err;
        int          s_wait;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    bit   port_active [NP];
    bit   done_pend   [NP];
    int   req_cyc     [NP];
    int   pready_cnt  [NP];
    int   cyc = 0, checks = 0, errors = 0;
    int   model_last = NP - 1;
    int   acc_cnt = 0, acc_obs = 0;
    bit   check_lat = 1'b0;

    function automatic txn_t mk(input int p, input logic [7:0] a, input logic w, input logic [31:0] wd,
                                input logic [31:0] rd, input logic e, input int ws);
        txn_t t;
        t.port = p; t.addr = a; t.wr = w; t.wdata = wd; t.s_rdata = rd; t.s_err = e; t.s_wait = ws;
        return t;
    endfunction

    function automatic bit aborts(input txn_t t);
        return (t.s_wait < 0) || (t.s_wait >= TO);
    endfunction
    function automatic logic [31:0] exp_rdata(input txn_t t);
        return aborts(t) ? 32'h0 : t.s_rdata;
    endfunction
    function automatic logic exp_err(input txn_t t);
        return aborts(t) ? 1'b1 : t.s_err;
    endfunction
    function automatic int exp_access(input txn_t t);
        return aborts(t) ? TO : t.s_wait + 1;
    endfunction
    function automatic int exp_lat(input txn_t t);
        return aborts(t) ? TO + 2 : t.s_wait + 3;
    endfunction

    task automatic step_raw();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic slave();
        if (dst_psel && dst_penable) begin
            acc_obs++;
            if (cur.s_wait >= 0 && acc_cnt == cur.s_wait) begin
                dst_pready = 1'b1; dst_prdata = cur.s_rdata; dst_pslverr = cur.s_err;
            end else begin
                dst_pready = 1'b0; dst_prdata = 32'hBAD0_0000 | acc_cnt; dst_pslverr = 1'b1;
            end
            acc_cnt++;
        end else begin
            dst_pready = 1'b0; dst_prdata = 32'hBAD0_FFFF; dst_pslverr = 1'b1;
        end
    endtask

    task automatic observe();
        txn_t t;
        if (dst_psel && !dst_penable) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL setup_unexpected: addr=%h, no transfer expected", dst_paddr);
            end else begin
                cur = exp_q[0]; acc_cnt = 0; acc_obs = 0;
                if (dst_paddr !== cur.addr || dst_pwrite !== cur.wr || dst_pwdata !== cur.wdata) begin
                    errors++;
                    $display("FAIL dst_setup: got addr=%h wr=%b wdata=%h, want addr=%h wr=%b wdata=%h",
                             dst_paddr, dst_pwrite, dst_pwdata, cur.addr, cur.wr, cur.wdata);
                end
                if (check_lat) begin
                    checks++;
                    if (cyc - req_cyc[cur.port] != 1) begin
                        errors++; $display("FAIL setup_latency: got %0d want 1", cyc - req_cyc[cur.port]);
                    end
                end
            end
        end
        checks++;
        if ($countones(src_pready) > 1) begin
            errors++; $display("FAIL pready_onehot: got %b", src_pready);
        end
        for (int p = 0; p < NP; p++) begin
            if (src_pready[p]) begin
                checks++;
                if (!port_active[p] || exp_q.size() == 0) begin
                    errors++; $display("FAIL spurious_pready: port %0d got pready=1 want 0", p);
                end else begin
                    t = exp_q.pop_front();
                    pready_cnt[p]++;
                    port_active[p] = 1'b0;
                    done_pend[p] = 1'b1;
                    if (t.port != p) begin
                        errors++; $display("FAIL grant_order: pready on port %0d want port %0d", p, t.port);
                    end
                    checks++;
                    if (src_prdata[p*WD +: WD] !== exp_rdata(t) || src_pslverr[p] !== exp_err(t)) begin
                        errors++;
                        $display("FAIL response: port %0d got prdata=%h slverr=%b want prdata=%h slverr=%b",
                                 p, src_prdata[p*WD +: WD], src_pslverr[p], exp_rdata(t), exp_err(t));
                    end
                    checks++;
                    if (dst_psel !== 1'b0 || acc_obs != exp_access(t)) begin
                        errors++;
                        $display("FAIL access_phase: got dst_psel=%b access_cycles=%0d want 0 and %0d",
                                 dst_psel, acc_obs, exp_access(t));
                    end
                    if (check_lat) begin
                        checks++;
                        if (cyc - req_cyc[p] != exp_lat(t)) begin
                            errors++;
                            $display("FAIL latency: port %0d got %0d want %0d", p, cyc - req_cyc[p], exp_lat(t));
                        end
                    end
                    $display("txn port=%0d addr=%h wr=%b prdata=%h slverr=%b at cycle %0d",
                             p, t.addr, t.wr, src_prdata[p*WD +: WD], src_pslverr[p], cyc);
                end
            end
        end
    endtask

    // A completed master keeps its access phase through the pready cycle, then drops it.
    task automatic step();
        step_raw();
        for (int p = 0; p < NP; p++) begin
            if (done_pend[p]) begin
                done_pend[p] = 1'b0; src_psel[p] = 1'b0; src_penable[p] = 1'b0;
            end
        end
        observe();
        slave();
    endtask

    task automatic drive_setup(input txn_t t);
        int p;
        p = t.port;
        src_psel[p] = 1'b1; src_penable[p] = 1'b0; src_pwrite[p] = t.wr;
        src_paddr[p*WA +: WA] = t.addr; src_pwdata[p*WD +: WD] = t.wdata;
        port_active[p] = 1'b1;
    endtask

    task automatic issue(input txn_t t0, input txn_t t1, input bit [1:0] mask);
        int p, last_p;
        last_p = model_last;
        if (mask[0]) drive_setup(t0);
        if (mask[1]) drive_setup(t1);
        for (int k = 1; k <= NP; k++) begin
            p = (model_last + k) % NP;
            if (mask[p]) begin
                if (p == 0) exp_q.push_back(t0);
                else        exp_q.push_back(t1);
                last_p = p;
            end
        end
        model_last = last_p;
        step();
        for (int q = 0; q < NP; q++) begin
            if (mask[q]) begin src_penable[q] = 1'b1; req_cyc[q] = cyc; end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((port_active[0] || port_active[1] || done_pend[0] || done_pend[1]) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (port_active[0] || port_active[1] || done_pend[0] || done_pend[1]) begin
            errors++; $display("FAIL wait_budget: transfers still open after %0d cycles", budget);
            for (int p = 0; p < NP; p++) begin
                port_active[p] = 1'b0; done_pend[p] = 1'b0; src_psel[p] = 1'b0; src_penable[p] = 1'b0;
            end
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step_raw(); step_raw();
        checks++;
        if (dst_psel !== 1'b0 || dst_penable !== 1'b0 || dst_pwrite !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: got psel=%b penable=%b pwrite=%b want 000", dst_psel, dst_penable, dst_pwrite);
        end
        checks++;
        if (dst_paddr !== '0 || dst_pwdata !== '0) begin
            errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", dst_paddr, dst_pwdata);
        end
        rst_n = 1'b1;
        step_raw();
        checks++;
        if (src_pready !== '0 || src_pslverr !== '0) begin
            errors++; $display("FAIL reset_src: got pready=%b slverr=%b want 00", src_pready, src_pslverr);
        end
        checks++;
        if (src_prdata !== '0) begin
            errors++; $display("FAIL reset_prdata: got %h want 0", src_prdata);
        end
    endtask

    task automatic test_single_read();
        txn_t t;
        check_lat = 1'b1;
        t = mk(0, 8'h10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        issue(t, t, 2'b01);
        run_until_idle(40);
    endtask

    task automatic test_write_err();
        txn_t t;
        check_lat = 1'b1;
        t = mk(1, 8'h04, 1'b1, 32'hCAFEF00D, 32'h1234_5678, 1'b1, 1);
        issue(t, t, 2'b10);
        run_until_idle(40);
    endtask

    task automatic test_round_robin();
        txn_t t0, t1;
        check_lat = 1'b0;
        pready_cnt[0] = 0; pready_cnt[1] = 0;
        for (int r = 0; r < 4; r++) begin
            t0 = mk(0, 8'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
            t1 = mk(1, 8'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
            issue(t0, t1, 2'b11);
            run_until_idle(80);
        end
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (pready_cnt[p] != 4) begin
                errors++; $display("FAIL pready_count: port %0d got %0d want 4", p, pready_cnt[p]);
            end
        end
    endtask

    task automatic test_timeout();
        txn_t t;
        check_lat = 1'b1;
        t = mk(0, 8'h20, 1'b0, 32'h0, 32'h77, 1'b0, -1);
        issue(t, t, 2'b01);
        run_until_idle(60);
        t = mk(1, 8'h24, 1'b0, 32'h0, 32'h5, 1'b0, TO - 1);
        issue(t, t, 2'b10);
        run_until_idle(60);
        t = mk(0, 8'h28, 1'b1, 32'h55AA, 32'h6, 1'b0, TO);
        issue(t, t, 2'b01);
        run_until_idle(60);
    endtask

    task automatic test_back_to_back();
        txn_t t;
        check_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t = mk(0, 8'(8'h40 + i), 1'(i), 32'h1000 + i, 32'hA000 + i, 1'b0, i);
            issue(t, t, 2'b01);
            run_until_idle(40);
        end
    endtask

    task automatic test_owner_drop();
        txn_t t;
        t = mk(0, 8'h30, 1'b0, 32'h0, 32'h99, 1'b0, 0);
        drive_setup(t);
        port_active[0] = 1'b0;
        step_raw();
        src_penable[0] = 1'b1;
        step_raw();
        checks++;
        if (dst_psel !== 1'b1 || dst_penable !== 1'b0) begin
            errors++; $display("FAIL drop_setup: got psel=%b penable=%b want 10", dst_psel, dst_penable);
        end
        src_psel[0] = 1'b0; src_penable[0] = 1'b0;
        cur = t; acc_cnt = 0; acc_obs = 0;
        slave();
        step_raw();
        checks++;
        if (dst_psel !== 1'b1 || dst_penable !== 1'b1) begin
            errors++; $display("FAIL drop_access: got psel=%b penable=%b want 11", dst_psel, dst_penable);
        end
        slave();
        for (int i = 0; i < 4; i++) begin
            step_raw();
            slave();
            checks++;
            if (src_pready !== '0 || dst_psel !== 1'b0) begin
                errors++; $display("FAIL drop_no_pready: got pready=%b dst_psel=%b want 00 and 0", src_pready, dst_psel);
            end
        end
        model_last = 0;
        check_lat = 1'b1;
        t = mk(1, 8'h34, 1'b0, 32'h0, 32'h4321, 1'b0, 0);
        issue(t, t, 2'b10);
        run_until_idle(40);
    endtask

    task automatic test_reset_mid_access();
        txn_t t0, t1;
        t0 = mk(0, 8'h50, 1'b1, 32'hFEED, 32'h0, 1'b0, -1);
        drive_setup(t0);
        port_active[0] = 1'b0;
        step_raw();
        src_penable[0] = 1'b1;
        step_raw(); step_raw(); step_raw();
        checks++;
        if (dst_penable !== 1'b1) begin
            errors++; $display("FAIL midreset_precond: got dst_penable=%b want 1", dst_penable);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dst_psel !== 1'b0 || dst_penable !== 1'b0 || dst_pwrite !== 1'b0 || dst_paddr !== '0 || dst_pwdata !== '0) begin
            errors++;
            $display("FAIL midreset_dst: got psel=%b penable=%b pwrite=%b addr=%h wdata=%h want all 0",
                     dst_psel, dst_penable, dst_pwrite, dst_paddr, dst_pwdata);
        end
        src_psel = '0; src_penable = '0;
        step_raw(); step_raw();
        checks++;
        if (src_pready !== '0) begin
            errors++; $display("FAIL midreset_pready: got %b want 00", src_pready);
        end
        rst_n = 1'b1;
        model_last = NP - 1;
        check_lat = 1'b0;
        t0 = mk(0, 8'h60, 1'b0, 32'h0, 32'hBEEF0000, 1'b0, 0);
        t1 = mk(1, 8'h61, 1'b0, 32'h0, 32'hBEEF0001, 1'b0, 0);
        issue(t0, t1, 2'b11);
        run_until_idle(60);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < NP; p++) begin
            port_active[p] = 1'b0; done_pend[p] = 1'b0; req_cyc[p] = 0; pready_cnt[p] = 0;
        end
        cur = mk(0, 8'h0, 1'b0, 32'h0, 32'h0, 1'b0, -1);
        test_reset();
        test_single_read();
        test_write_err();
        test_round_robin();
        test_timeout();
        test_back_to_back();
        test_owner_drop();
        test_reset_mid_access();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/opendap_apb_arbiter.md
OPENDAP_APB_ARBITER -- requirements
Module: opendap_apb_arbiter

Interface
REQ-001 SHALL have parameters: N_PORTS, default 2, number of upstream APB requesters (1..16); W_ADDR, default 8, address width; W_DATA, default 32, data width; TIMEOUT, default 0, maximum downstream access-phase cycles before abort (0 = never abort).
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- src_psel  input  N_PORTS  per-port APB psel
- src_penable  input  N_PORTS  per-port APB penable
- src_pwrite  input  N_PORTS  per-port APB pwrite
- src_paddr  input  N_PORTS*W_ADDR  port i at bits [i*W_ADDR +: W_ADDR]
- src_pwdata  input  N_PORTS*W_DATA  port i at bits [i*W_DATA +: W_DATA]
- src_prdata  output  N_PORTS*W_DATA  every slice equals the response register
- src_pready  output  N_PORTS  per-port pready
- src_pslverr  output  N_PORTS  per-port pslverr, equals the response error bit
- dst_psel, dst_penable, dst_pwrite  output  1 each  downstream APB control
- dst_paddr  output  W_ADDR; dst_pwdata  output  W_DATA  downstream address/data
- dst_prdata  input  W_DATA; dst_pready  input  1; dst_pslverr  input  1  downstream response

Function
REQ-003 Port i SHALL request when src_psel[i] && src_penable[i] (access phase); setup phases are ignored.
REQ-004 The FSM SHALL have states IDLE, SETUP, ACCESS, RESP; outputs are registered.
REQ-005 IDLE: if any port requests, the FSM SHALL grant one by round-robin, capture that port's paddr/pwdata/pwrite into the downstream registers, record the owner, and go to SETUP next cycle.
REQ-006 Round-robin SHALL search from (last_grant+1) mod N_PORTS upward; last_grant updates on each grant; reset value N_PORTS-1, so port 0 wins first.
REQ-007 SETUP: dst_psel=1, dst_penable=0; next state ACCESS.
REQ-008 ACCESS: dst_psel=1, dst_penable=1; on dst_pready=1 the FSM SHALL capture {dst_prdata, dst_pslverr} into the response register and go to RESP.
REQ-009 With TIMEOUT>0, a counter SHALL count ACCESS cycles with dst_pready=0; when it reaches TIMEOUT the FSM SHALL drop dst_psel/dst_penable, load response prdata=0, pslverr=1, and go to RESP. A pready arriving on the same cycle as the limit takes precedence over the abort.
REQ-010 RESP: src_pready[owner]=1 for exactly one cycle, all other src_pready bits 0; dst_psel=0; next state IDLE.
REQ-011 src_pready[i] SHALL be 0 in every other cycle; minimum upstream access phase is 4 cycles (IDLE grant, SETUP, ACCESS with immediate pready, RESP).
REQ-012 A port that re-enters setup in the cycle after its RESP SHALL NOT be counted as requesting until its penable=1 (no double service).
REQ-013 If the owner drops src_psel during SETUP/ACCESS (illegal APB), the downstream transfer SHALL complete normally and the response SHALL be discarded: no pready pulse; go to IDLE.
REQ-014 Simultaneous requests SHALL be served one per transaction in round-robin order; no port waits more than N_PORTS-1 other transactions.
REQ-015 N_PORTS=1 SHALL degenerate to a registered pass-through with identical timing.

Reset
REQ-016 On rst_n low, all state SHALL reset asynchronously: FSM IDLE; dst_psel/dst_penable/dst_pwrite 0; dst_paddr/dst_pwdata 0; response register 0; src_pready all 0; timeout counter 0; last_grant N_PORTS-1.
REQ-017 Reset during an in-flight transfer SHALL drop dst_psel immediately, with no pready pulse to any port.

Structure
REQ-018 FSM state encodings and the timeout counter width (clog2(TIMEOUT+1), minimum 1) SHALL be local constants; no shared package is required.
REQ-019 The round-robin picker (request vector plus last_grant in, one-hot grant and index out) SHALL be a sub-module, opendap_rr_arbiter, reusable by other OpenDAP blocks.

Verification
REQ-020 Single port 0 read of paddr=0x10, downstream prdata=0xDEADBEEF with pready at the first ACCESS cycle -> dst_psel on cycle +1, src_pready[0] on cycle +3, src_prdata=0xDEADBEEF, pslverr=0.
REQ-021 Ports 0 and 1 request on the same cycle, repeated 4 times -> grant order 0,1,0,1, and each port sees exactly one pready per transfer.
REQ-022 TIMEOUT=8, downstream never ready -> dst_psel drops after 8 ACCESS cycles, requester sees pready=1, pslverr=1, prdata=0.
REQ-023 TIMEOUT=8, dst_pready on the 8th ACCESS cycle with prdata=0x5 -> normal response 0x5, pslverr=0.
REQ-024 rst_n asserted mid-ACCESS -> all outputs at reset values in the same cycle; after release, port 0 is granted first.
REQ-025 Write of 0xCAFEF00D to paddr=0x04 from port 1 with dst_pslverr=1 -> dst_pwrite=1, dst_pwdata=0xCAFEF00D, src_pslverr[1]=1 on the pready cycle.
